// File: rtl/spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
// Shared definitions for the SPI slave: data width, the dummy byte sent when
// nothing has been queued, the SPI mode encodings and the FSM state type.
// Helper functions turn the CPOL/CPHA parameters into a mode and answer which
// spi_clk edge is the leading one and which edge samples mosi.
// ---------------------------------------------------------------------------
package spi_slave_pkg;

    localparam int SPI_DATA_W = 8;
    localparam logic [SPI_DATA_W-1:0] SPI_DUMMY_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,   // CPOL=0 CPHA=0
        SPI_MODE1 = 2'd1,   // CPOL=0 CPHA=1
        SPI_MODE2 = 2'd2,   // CPOL=1 CPHA=0
        SPI_MODE3 = 2'd3    // CPOL=1 CPHA=1
    } spi_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    function automatic spi_mode_e spi_mode(input int cpol, input int cpha);
        spi_mode_e m;
        case ({cpol != 0, cpha != 0})
            2'b00:   m = SPI_MODE0;
            2'b01:   m = SPI_MODE1;
            2'b10:   m = SPI_MODE2;
            default: m = SPI_MODE3;
        endcase
        return m;
    endfunction

    // With the clock idling low the leading edge is a rising edge.
    function automatic logic lead_is_rise(input spi_mode_e m);
        return (m == SPI_MODE0) || (m == SPI_MODE1);
    endfunction

    // CPHA=0 modes sample mosi on the leading edge.
    function automatic logic sample_on_lead(input spi_mode_e m);
        return (m == SPI_MODE0) || (m == SPI_MODE2);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync
// Brings one asynchronous SPI pin into the clk domain through two flops,
// then registers the synchronized value once more so that rise/fall strobes
// and the level come out of the same flop stage and stay aligned.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (all stages load RESET_VAL)
//   din    in   asynchronous pin
//   level  out  synchronized pin value, aligned with rise/fall
//   rise   out  one-cycle strobe on a 0->1 change
//   fall   out  one-cycle strobe on a 1->0 change
// ---------------------------------------------------------------------------
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic stable;

    // Two synchronizer flops, then the registered level and edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= RESET_VAL;
            stable <= RESET_VAL;
            level  <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= din;
            stable <= meta;
            level  <= stable;
            rise   <= stable & ~level;
            fall   <= ~stable & level;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI slave, MSB first, 8-bit frames, any of the four CPOL/CPHA modes.
// All pins are oversampled by clk (spi_clk must be at most clk/8). A single
// hold register buffers the next byte to transmit; if it is empty when a
// byte is due, the dummy byte is sent and tx_underrun pulses.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   spi_clk/nss/mosi     SPI pins from the master
//   spi_miso, _oe        serial out and its pad enable (high while selected)
//   tx_data/valid/ready  byte to send, valid/ready handshake into hold reg
//   rx_data, rx_valid    last received byte, one-cycle strobe per byte
//   tx_underrun          one-cycle strobe when the dummy byte is used
//   busy                 high while selected
// ---------------------------------------------------------------------------
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_clk,
    input  logic                  spi_nss,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [SPI_DATA_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam spi_mode_e MODE           = spi_mode(CPOL, CPHA);
    localparam logic      LEAD_IS_RISE   = lead_is_rise(MODE);
    localparam logic      SAMPLE_ON_LEAD = sample_on_lead(MODE);

    logic sclk_level, sclk_rise, sclk_fall;
    logic nss_level, nss_rise, nss_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync_bits;

    spi_sync #(.RESET_VAL(CPOL != 0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi_clk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.RESET_VAL(1'b1)) u_sync_nss (
        .clk(clk), .rst_n(rst_n), .din(spi_nss),
        .level(nss_level), .rise(nss_rise), .fall(nss_fall)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the edges of spi_clk and the level of mosi carry information.
    assign unused_sync_bits = ^{sclk_level, mosi_rise, mosi_fall};

    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = LEAD_IS_RISE ? sclk_rise : sclk_fall;
    assign trail_edge  = LEAD_IS_RISE ? sclk_fall : sclk_rise;
    assign sample_edge = SAMPLE_ON_LEAD ? lead_edge  : trail_edge;
    assign shift_edge  = SAMPLE_ON_LEAD ? trail_edge : lead_edge;

    spi_state_e            state;
    logic [2:0]            bit_cnt;
    logic [SPI_DATA_W-1:0] rx_shift;
    logic [SPI_DATA_W-1:0] tx_shift;
    logic                  need_load;
    logic                  underrun_pending;
    logic                  armed;
    logic [1:0]            settle_cnt;
    logic                  hold_full;
    logic [SPI_DATA_W-1:0] hold_data;

    logic                  frame_start;
    logic                  frame_reload;
    logic                  load_frame;
    logic [SPI_DATA_W-1:0] load_byte;

    // A frame starts only on a genuine nss fall seen after reset settled;
    // back-to-back bytes reload on the first shift edge after a full byte.
    assign frame_start  = (state == ST_IDLE) && armed && nss_fall;
    assign frame_reload = (state == ST_SHIFT) && !nss_rise && shift_edge && need_load;
    assign load_frame   = frame_start || frame_reload;
    assign load_byte    = hold_full ? hold_data : SPI_DUMMY_BYTE;
    assign tx_ready     = ~hold_full;

    // The nss synchronizer resets high, so if the pin is low when reset is
    // released it would look like a fall. Wait until the pipeline holds real
    // pin samples and nss has been seen high before accepting a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= 2'd0;
            armed      <= 1'b0;
        end else if (settle_cnt != 2'd3) begin
            settle_cnt <= settle_cnt + 2'd1;
        end else if (nss_level) begin
            armed <= 1'b1;
        end
    end

    // Hold register: a write is only accepted while empty, so a write in
    // the same cycle as a load can never collide with the load emptying it;
    // such a write simply stays for the following byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (load_frame && hold_full) begin
            hold_full <= 1'b0;
        end
    end

    // Frame FSM with all SPI-side outputs registered.
    // In CPHA=0 modes the reload happens on the trailing edge that closes
    // every byte, including the last one before nss rises. A dummy reload
    // there therefore defers its tx_underrun until the master really clocks
    // the next byte, otherwise every frame would end with a false underrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            bit_cnt          <= 3'd0;
            rx_shift         <= '0;
            tx_shift         <= '0;
            need_load        <= 1'b0;
            underrun_pending <= 1'b0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            tx_underrun      <= 1'b0;
            busy             <= 1'b0;
            spi_miso         <= 1'b0;
            spi_miso_oe      <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state            <= ST_SHIFT;
                        busy             <= 1'b1;
                        spi_miso_oe      <= 1'b1;
                        bit_cnt          <= 3'd0;
                        rx_shift         <= '0;
                        need_load        <= 1'b0;
                        underrun_pending <= 1'b0;
                        tx_shift         <= load_byte;
                        spi_miso         <= load_byte[SPI_DATA_W-1];
                        tx_underrun      <= ~hold_full;
                    end
                end
                ST_SHIFT: begin
                    if (nss_rise) begin
                        state            <= ST_IDLE;
                        busy             <= 1'b0;
                        spi_miso_oe      <= 1'b0;
                        spi_miso         <= 1'b0;
                        bit_cnt          <= 3'd0;
                        need_load        <= 1'b0;
                        underrun_pending <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[SPI_DATA_W-2:0], mosi_level};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {rx_shift[SPI_DATA_W-2:0], mosi_level};
                                rx_valid  <= 1'b1;
                                need_load <= 1'b1;
                            end
                            if (underrun_pending) begin
                                tx_underrun      <= 1'b1;
                                underrun_pending <= 1'b0;
                            end
                        end
                        if (shift_edge) begin
                            if (need_load) begin
                                tx_shift  <= load_byte;
                                spi_miso  <= load_byte[SPI_DATA_W-1];
                                need_load <= 1'b0;
                                if (!hold_full) begin
                                    if (CPHA != 0) begin
                                        tx_underrun <= 1'b1;
                                    end else begin
                                        underrun_pending <= 1'b1;
                                    end
                                end
                            end else if (bit_cnt != 3'd0) begin
                                tx_shift <= {tx_shift[SPI_DATA_W-2:0], 1'b0};
                                spi_miso <= tx_shift[SPI_DATA_W-2];
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Two instances: dut0 in mode 0 and dut3 in mode 3 (CPOL=1, CPHA=1). A bench
// master clocks bytes at clk/8, the model tracks the hold register contents,
// expected received bytes and expected strobe counts.
// ---------------------------------------------------------------------------
module tb_spi_slave;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       sck0, nss0, sck3, nss3, mosi;
    logic [7:0] tx_data;
    logic       tx_valid0, tx_valid3;

    logic       miso0, oe0, ready0, rxv0, ur0, busy0;
    logic       miso3, oe3, ready3, rxv3, ur3, busy3;
    logic [7:0] rx0, rx3;

    logic       c_miso, c_oe, c_ready, c_rxv, c_ur, c_busy;
    logic [7:0] c_rx;

    int         total = 0;
    int         bad = 0;
    int         rxv_seen = 0, rxv_exp = 0;
    int         ur_seen = 0, ur_exp = 0;
    logic [7:0] hold_q[$];
    logic [7:0] rx_exp_q[$];
    logic [7:0] last_rx[2];
    logic [7:0] mi, mi2, exp_tx, exp_tx2;
    int         ur_before;

    spi_slave #(.CPOL(0), .CPHA(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sck0), .spi_nss(nss0), .spi_mosi(mosi),
        .spi_miso(miso0), .spi_miso_oe(oe0), .tx_data(tx_data), .tx_valid(tx_valid0),
        .tx_ready(ready0), .rx_data(rx0), .rx_valid(rxv0), .tx_underrun(ur0), .busy(busy0)
    );

    spi_slave #(.CPOL(1), .CPHA(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sck3), .spi_nss(nss3), .spi_mosi(mosi),
        .spi_miso(miso3), .spi_miso_oe(oe3), .tx_data(tx_data), .tx_valid(tx_valid3),
        .tx_ready(ready3), .rx_data(rx3), .rx_valid(rxv3), .tx_underrun(ur3), .busy(busy3)
    );

    assign c_miso  = sel ? miso3  : miso0;
    assign c_oe    = sel ? oe3    : oe0;
    assign c_ready = sel ? ready3 : ready0;
    assign c_rxv   = sel ? rxv3   : rxv0;
    assign c_ur    = sel ? ur3    : ur0;
    assign c_busy  = sel ? busy3  : busy0;
    assign c_rx    = sel ? rx3    : rx0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Per-cycle comparison of the selected DUT against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("oe_vs_busy", c_oe, c_busy);
            if (!c_oe) check_output("miso_idle_low", c_miso, 1'b0);
            if (c_ur) ur_seen++;
            if (c_rxv) begin
                rxv_seen++;
                check_output("rx_expected_pending", rx_exp_q.size() != 0, 1'b1);
                if (rx_exp_q.size() != 0) last_rx[sel] = rx_exp_q.pop_front();
                check_output("rx_data_on_valid", c_rx, last_rx[sel]);
            end else begin
                check_output("rx_data_hold", c_rx, last_rx[sel]);
            end
        end
    end

    task automatic next_tx_expect(output logic [7:0] b);
        if (hold_q.size() != 0) begin
            b = hold_q.pop_front();
        end else begin
            b = 8'hFF;
            ur_exp++;
        end
    endtask

    task automatic tx_write(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0;
        tx_data = b;
        if (sel) tx_valid3 = 1'b1; else tx_valid0 = 1'b1;
        while (!c_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = c_ready;
        check_output("tx_accept", acc, 1'b1);
        @(negedge clk);
        tx_valid0 = 1'b0;
        tx_valid3 = 1'b0;
        if (acc) hold_q.push_back(b);
    endtask

    // Master side of nbits bit-times; returns what was seen on miso.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi_out);
        mi_out = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (sel) sck3 = 1'b0;
            mosi = mo[7-i];
            wait_clks(4);
            mi_out[7-i] = c_miso;
            if (i == 7) begin
                rx_exp_q.push_back(mo);
                rxv_exp++;
            end
            if (sel) sck3 = 1'b1; else sck0 = 1'b1;
            wait_clks(4);
            if (!sel) sck0 = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic level);
        if (sel) nss3 = level; else nss0 = level;
        wait_clks(level ? 10 : 8);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_ready0"}, ready0, 1'b1);
        check_output({tag, "_rx0"},    rx0,    8'h00);
        check_output({tag, "_rxv0"},   rxv0,   1'b0);
        check_output({tag, "_ur0"},    ur0,    1'b0);
        check_output({tag, "_busy0"},  busy0,  1'b0);
        check_output({tag, "_miso0"},  miso0,  1'b0);
        check_output({tag, "_oe0"},    oe0,    1'b0);
        check_output({tag, "_ready3"}, ready3, 1'b1);
        check_output({tag, "_rx3"},    rx3,    8'h00);
        check_output({tag, "_busy3"},  busy3,  1'b0);
        check_output({tag, "_oe3"},    oe3,    1'b0);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        sck0 = 1'b0; nss0 = 1'b1; sck3 = 1'b1; nss3 = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid0 = 1'b0; tx_valid3 = 1'b0;
        last_rx[0] = 8'h00; last_rx[1] = 8'h00;
        wait_clks(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        wait_clks(10);

        // Mode 0, A5 preloaded, master sends 3C.
        $display("[TB] mode 0 basic frame");
        tx_write(8'hA5);
        check_output("ready_after_write", c_ready, hold_q.size() == 0);
        apply_stimulus(1'b0);
        next_tx_expect(exp_tx);
        check_output("busy_in_frame", c_busy, 1'b1);
        check_output("oe_in_frame", c_oe, 1'b1);
        spi_bits(8'h3C, 8, mi);
        wait_clks(4);
        apply_stimulus(1'b1);
        check_output("miso_model_f1", mi, exp_tx);
        check_output("miso_lit_A5", mi, 8'hA5);
        check_output("rx_lit_3C", rx0, 8'h3C);
        check_output("rxv_count_f1", rxv_seen, rxv_exp);
        check_output("rxv_lit_1", rxv_seen, 1);
        check_output("ur_count_f1", ur_seen, ur_exp);

        // Underrun frame.
        $display("[TB] underrun frame");
        ur_before = ur_seen;
        apply_stimulus(1'b0);
        next_tx_expect(exp_tx);
        spi_bits(8'h55, 8, mi);
        wait_clks(4);
        apply_stimulus(1'b1);
        check_output("miso_model_ur", mi, exp_tx);
        check_output("miso_lit_FF", mi, 8'hFF);
        check_output("ur_once", ur_seen - ur_before, 1);
        check_output("rx_lit_55", rx0, 8'h55);

        // Back-to-back bytes, hold refilled with 12 during byte 1.
        $display("[TB] back-to-back frames");
        tx_write(8'hC3);
        apply_stimulus(1'b0);
        next_tx_expect(exp_tx);
        fork
            spi_bits(8'h6E, 8, mi);
            begin
                wait_clks(10);
                tx_write(8'h12);
            end
        join
        next_tx_expect(exp_tx2);
        spi_bits(8'hB1, 8, mi2);
        wait_clks(4);
        apply_stimulus(1'b1);
        check_output("miso_model_b1", mi, exp_tx);
        check_output("miso_model_b2", mi2, exp_tx2);
        check_output("miso_lit_C3", mi, 8'hC3);
        check_output("miso_lit_12", mi2, 8'h12);
        check_output("rx_lit_B1", rx0, 8'hB1);
        check_output("rxv_count_b2b", rxv_seen, rxv_exp);
        check_output("rxv_lit_4", rxv_seen, 4);
        check_output("ur_count_b2b", ur_seen, ur_exp);

        // Abort after 4 bits, then a clean frame.
        $display("[TB] abort mid-byte");
        tx_write(8'h96);
        apply_stimulus(1'b0);
        next_tx_expect(exp_tx);
        spi_bits(8'hA0, 4, mi);
        wait_clks(4);
        apply_stimulus(1'b1);
        check_output("miso_abort_nibble", mi[7:4], exp_tx[7:4]);
        check_output("rxv_count_abort", rxv_seen, rxv_exp);
        check_output("ready_after_abort", c_ready, 1'b1);
        tx_write(8'h5A);
        apply_stimulus(1'b0);
        next_tx_expect(exp_tx);
        spi_bits(8'hE7, 8, mi);
        wait_clks(4);
        apply_stimulus(1'b1);
        check_output("miso_lit_5A", mi, 8'h5A);
        check_output("rx_lit_E7", rx0, 8'hE7);
        check_output("ur_count_abort", ur_seen, ur_exp);

        // Mode 3 instance.
        $display("[TB] mode 3 frame");
        sel = 1'b1;
        tx_write(8'h81);
        apply_stimulus(1'b0);
        next_tx_expect(exp_tx);
        spi_bits(8'hF0, 8, mi);
        wait_clks(4);
        apply_stimulus(1'b1);
        check_output("miso_model_m3", mi, exp_tx);
        check_output("miso_lit_81", mi, 8'h81);
        check_output("rx_lit_F0", rx3, 8'hF0);
        check_output("rxv_count_m3", rxv_seen, rxv_exp);
        check_output("ur_count_m3", ur_seen, ur_exp);

        // Reset in the middle of a mode 0 frame.
        $display("[TB] reset mid-frame");
        sel = 1'b0;
        tx_write(8'h3A);
        apply_stimulus(1'b0);
        next_tx_expect(exp_tx);
        spi_bits(8'h11, 3, mi);
        check_output("miso_pre_reset", mi[7:5], exp_tx[7:5]);
        rst_n = 1'b0;
        nss0 = 1'b1;
        sck0 = 1'b0;
        hold_q.delete();
        rx_exp_q.delete();
        last_rx[0] = 8'h00;
        last_rx[1] = 8'h00;
        wait_clks(2);
        check_reset_values("midreset");
        rst_n = 1'b1;
        wait_clks(10);
        tx_write(8'hC6);
        apply_stimulus(1'b0);
        next_tx_expect(exp_tx);
        spi_bits(8'h9B, 8, mi);
        wait_clks(4);
        apply_stimulus(1'b1);
        check_output("miso_lit_C6", mi, 8'hC6);
        check_output("rx_lit_9B", rx0, 8'h9B);
        check_output("rxv_count_final", rxv_seen, rxv_exp);
        check_output("ur_count_final", ur_seen, ur_exp);
        check_output("ready_final", c_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter CPOL, default 0: idle level of spi_clk.
REQ-002 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have ports: clk  input  1  system clock, single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 spi_clk  input  1  serial clock from master, asynchronous to clk, frequency ≤ clk/8.
REQ-006 spi_nss  input  1  chip select, active low.
REQ-007 spi_mosi  input  1  serial data in, MSB first.
REQ-008 spi_miso  output  1  serial data out, MSB first.
REQ-009 spi_miso_oe  output  1  tri-state enable for the pad, high only while selected.
REQ-010 tx_data  input  8  byte to send; tx_valid  input  1; tx_ready  output  1  (valid/ready handshake).
REQ-011 rx_data  output  8  last received byte; rx_valid  output  1  one-cycle strobe.
REQ-012 tx_underrun  output  1  one-cycle strobe; busy  output  1  high while selected.

Function
REQ-013 spi_clk, spi_nss and spi_mosi SHALL each pass a 2-flop synchronizer, followed by a registered edge detect.
REQ-014 Leading and trailing edges SHALL be derived from the synchronized spi_clk and CPOL.
REQ-015 FSM states: IDLE (nss high) and SHIFT (nss low); only a synchronized nss fall/rise moves between them.
REQ-016 One 8-bit hold register: tx_ready = hold empty; a write is accepted when tx_valid && tx_ready.
REQ-017 Frame load:
- occurs on nss fall, and for back-to-back frames on the shift edge that ends bit 7.
- takes the hold register if it was full at the start of that cycle, and empties it.
- otherwise loads 8'hFF and pulses tx_underrun.
REQ-018 A tx write in the same cycle as a load SHALL stay in the hold register for the next frame.
REQ-019 CPHA=0: MSB on spi_miso from the load; mosi sampled on leading edge; next bit shifted out on trailing edge.
REQ-020 CPHA=1: each bit, including the MSB, driven on leading edge; mosi sampled on trailing edge.
REQ-021 A 3-bit counter SHALL count sampling edges and wrap 7→0 with no lost edge.
REQ-022 On the 8th sample, rx_data SHALL update and rx_valid SHALL pulse one clk, within 4 clk of the pin edge.
REQ-023 rx_data SHALL hold its value until the next complete byte; there is no back-pressure.
REQ-024 nss rise mid-byte SHALL abort:
- partial rx dropped, no rx_valid.
- counter cleared.
- loaded tx byte discarded (not returned to hold).
REQ-025 spi_miso_oe and busy SHALL follow synchronized ~nss; spi_miso SHALL be 0 when oe is low.
REQ-026 spi_clk edges while nss is high SHALL be ignored.

Reset
REQ-027 While rst_n = 0, all outputs SHALL be: tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, spi_miso=0, spi_miso_oe=0.
REQ-028 Reset SHALL clear the FSM to IDLE, empty the hold register and clear the synchronizers to nss=1 and spi_clk=CPOL.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for a fresh nss fall.

Structure
REQ-030 SPI_DATA_W (8), the SPI mode encodings and the dummy byte 8'hFF SHALL live in the shared defines file.
REQ-031 One sub-module spi_sync (2-flop synchronizer plus rise/fall detect) SHALL be instantiated 3 times.

Verification
REQ-032 Mode 0, tx 8'hA5 preloaded, master sends 8'h3C at clk/8 → miso shows 10100101, rx_data=8'h3C, one rx_valid pulse.
REQ-033 No tx write, one frame → miso 8'hFF, tx_underrun pulses once at nss fall.
REQ-034 Two back-to-back frames, nss held low, hold refilled with 8'h12 during frame 1 → frame 2 miso=8'h12, two rx_valid pulses, no gap bit.
REQ-035 nss rises after 4 bits → no rx_valid, tx_ready=1, next frame starts at bit 7.
REQ-036 CPHA=1 and CPOL=1, tx 8'h81, mosi 8'hF0 → miso 10000001, rx_data=8'hF0.
REQ-037 rst_n pulsed low mid-frame → all outputs at reset values, next full frame received correctly.
